// File: rtl/booth_div320_64_pkg.sv
// Shared widths and state encoding for the 320/64 restoring divider.
//   A_W   quotient width (multiplier A operand width)
//   B_W   divisor / remainder width (multiplier B operand width)
//   P_W   dividend width, always A_W + B_W
//   CNT_W step counter width, $clog2(A_W)
package booth_div320_64_pkg;

    localparam int unsigned A_W   = 256;
    localparam int unsigned B_W   = 64;
    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned CNT_W = $clog2(A_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division step: shift one dividend bit into the partial
// remainder and subtract the divisor when it fits.
//   rem      current partial remainder (always < d)
//   bit_in   next dividend bit, MSB first
//   d        divisor
//   rem_nxt  partial remainder after the step
//   qbit     quotient bit produced by the step
module booth_div_step
    import booth_div320_64_pkg::*;
(
    input  logic [B_W-1:0] rem,
    input  logic           bit_in,
    input  logic [B_W-1:0] d,
    output logic [B_W-1:0] rem_nxt,
    output logic           qbit
);

    logic [B_W:0] t;
    logic [B_W:0] diff;

    // rem < d implies t < 2*d, so t-d always fits back into B_W bits
    always_comb begin
        t       = {rem, bit_in};
        diff    = t - {1'b0, d};
        qbit    = (t >= {1'b0, d});
        rem_nxt = qbit ? diff[B_W-1:0] : t[B_W-1:0];
    end

endmodule

// File: rtl/booth_div320_64.sv
// Sequential unsigned divider P / B -> quotient A, remainder R, one quotient
// bit per clock, valid/ready handshake on both sides.
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_ready    dividend/divisor handshake; in_ready = idle
//   P, B                 320-bit dividend, 64-bit divisor
//   out_valid/out_ready  result handshake
//   A, R                 256-bit quotient, 64-bit remainder
//   dbz, ovf             divide-by-zero, quotient-overflow flags
module booth_div320_64
    import booth_div320_64_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P_W-1:0] P,
    input  logic [B_W-1:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W-1:0] A,
    output logic [B_W-1:0] R,
    output logic           dbz,
    output logic           ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W - 1);

    state_t           state;
    state_t           state_nxt;
    logic [B_W-1:0]   rem;
    logic [A_W-1:0]   dvd;
    logic [B_W-1:0]   d;
    logic [CNT_W-1:0] cnt;

    logic             b_zero;
    logic             p_ovf;
    logic [B_W-1:0]   rem_nxt;
    logic             qbit;
    logic [A_W-1:0]   dvd_nxt;

    assign in_ready = (state == ST_IDLE);

    // Error pre-check on the incoming operands; a high half >= B would need
    // more than A_W quotient bits.
    assign b_zero  = (B == '0);
    assign p_ovf   = (P[P_W-1:A_W] >= B);
    assign dvd_nxt = {dvd[A_W-2:0], qbit};

    booth_div_step u_step (
        .rem     (rem),
        .bit_in  (dvd[A_W-1]),
        .d       (d),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = (b_zero || p_ovf) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and result registers; the quotient shifts into dvd as the
    // dividend bits shift out, so one register serves both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            dvd       <= '0;
            d         <= '0;
            cnt       <= '0;
            A         <= '0;
            R         <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        rem       <= P[P_W-1:A_W];
                        dvd       <= P[A_W-1:0];
                        d         <= B;
                        cnt       <= '0;
                        A         <= '0;
                        R         <= '0;
                        dbz       <= 1'b0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        // divide-by-zero takes priority over overflow
                        if (b_zero) begin
                            A         <= '1;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                        end else if (p_ovf) begin
                            A         <= '1;
                            ovf       <= 1'b1;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        A         <= dvd_nxt;
                        R         <= rem_nxt;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div320_64.sv
// Scoreboard bench for booth_div320_64: expected results are queued when an
// operation is driven and compared when the divider presents its result.
module tb_booth_div320_64;
    import booth_div320_64_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [P_W-1:0] P;
    logic [B_W-1:0] B;
    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] A;
    logic [B_W-1:0] R;
    logic           dbz;
    logic           ovf;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] r;
        logic           dbz;
        logic           ovf;
        logic [31:0]    lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [A_W-1:0] t1_a;
    logic [B_W-1:0] t1_b;
    logic [P_W-1:0] t1_p;

    booth_div320_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .R         (R),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model built on the simulator's wide division
    function automatic exp_t model(input logic [P_W-1:0] p, input logic [B_W-1:0] b);
        exp_t e;
        logic [P_W-1:0] q;
        logic [P_W-1:0] m;
        e = '0;
        if (b == '0) begin
            e.a = '1; e.dbz = 1'b1; e.lat = 32'd0;
        end else if (p[P_W-1:A_W] >= b) begin
            e.a = '1; e.ovf = 1'b1; e.lat = 32'd0;
        end else begin
            q = p / {{A_W{1'b0}}, b};
            m = p % {{A_W{1'b0}}, b};
            e.a = q[A_W-1:0];
            e.r = m[B_W-1:0];
            e.lat = 32'(A_W);
        end
        return e;
    endfunction

    // Drive one accept edge; called at posedge+1, returns at accept edge+1
    task automatic send(input logic [P_W-1:0] p, input logic [B_W-1:0] b, input bit push);
        P = p; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(model(p, b));
    endtask

    // Edges after the accept edge until out_valid; -1 if the budget expires
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; P = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, A, R, dbz, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b A=%h R=%h dbz=%b ovf=%b, want all zero", out_valid, A, R, dbz, ovf);
        end
        rst = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Exact multiple: P = a*b, B = b
    task automatic test_exact(input string tag);
        exp_t e;
        int lat;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: in_ready=%b want 1", tag, in_ready);
        end
        send(t1_p, t1_b, 1'b1);
        total++;
        if ({out_valid, A, R} !== '0) begin
            bad++;
            $display("FAIL %s_cleared: ov=%b A=%h R=%h want zero after accept", tag, out_valid, A, R);
        end
        wait_out(lat);
        e = sb.pop_front();
        total++;
        if ({A, R, dbz, ovf} !== {e.a, e.r, e.dbz, e.ovf} || A !== t1_a) begin
            bad++;
            $display("FAIL %s_result: A=%h R=%h dbz=%b ovf=%b want A=%h R=%h", tag, A, R, dbz, ovf, t1_a, e.r);
        end
        total++;
        if (lat !== int'(e.lat)) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", tag, lat, e.lat);
        end
        release_out();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handshake: ov=%b ir=%b want 0/1", tag, out_valid, in_ready);
        end
    endtask

    // Normal, error and boundary operands through the scoreboard
    task automatic test_ops();
        logic [P_W-1:0] pv[8];
        logic [B_W-1:0] bv[8];
        string          nm[8];
        logic [B_W-1:0] rb;
        exp_t e;
        int lat;
        rb = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
        pv[0] = 320'd100;            bv[0] = 64'd7;   nm[0] = "div_100_7";
        pv[1] = 320'd5;              bv[1] = 64'd9;   nm[1] = "div_5_9";
        pv[2] = 320'd5;              bv[2] = 64'd0;   nm[2] = "dbz";
        pv[3] = {64'h1, 256'h0};     bv[3] = 64'h1;   nm[3] = "ovf";
        pv[4] = {64'h0, {8{$urandom}}}; bv[4] = 64'd0; nm[4] = "dbz_wins";
        pv[5] = {rb, 256'h0};        bv[5] = rb;      nm[5] = "ovf_equal";
        pv[6] = {rb - 64'd1, {8{32'hffff_ffff}}}; bv[6] = rb; nm[6] = "max_quot";
        pv[7] = {rb >> 1, {8{$urandom}}};  bv[7] = rb; nm[7] = "random";
        for (int i = 0; i < 8; i++) begin
            send(pv[i], bv[i], 1'b1);
            wait_out(lat);
            e = sb.pop_front();
            total++;
            if ({A, R, dbz, ovf} !== {e.a, e.r, e.dbz, e.ovf}) begin
                bad++;
                $display("FAIL %s_result: A=%h R=%h dbz=%b ovf=%b want A=%h R=%h dbz=%b ovf=%b",
                         nm[i], A, R, dbz, ovf, e.a, e.r, e.dbz, e.ovf);
            end
            total++;
            if (lat !== int'(e.lat)) begin
                bad++;
                $display("FAIL %s_latency: got %0d want %0d", nm[i], lat, e.lat);
            end
            release_out();
        end
    endtask

    // Hold the result under backpressure, then run the next op back-to-back
    task automatic test_back_to_back();
        exp_t e;
        int lat;
        send(320'd100, 64'd7, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; P = 320'd999; B = 64'd3;
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, A, R} !== {1'b1, 1'b0, e.a, e.r}) begin
                bad++;
                $display("FAIL hold_%0d: ov=%b ir=%b A=%h R=%h want 1/0 A=%h R=%h", i, out_valid, in_ready, A, R, e.a, e.r);
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        send(320'd5, 64'd9, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        total++;
        if ({A, R, dbz, ovf} !== {e.a, e.r, e.dbz, e.ovf} || lat !== int'(e.lat)) begin
            bad++;
            $display("FAIL b2b_result: A=%h R=%h lat=%0d want A=%h R=%h lat=%0d", A, R, lat, e.a, e.r, e.lat);
        end
        release_out();
    endtask

    // Reset mid-RUN discards the operation
    task automatic test_reset_abort();
        int lat;
        send(t1_p, t1_b, 1'b0);
        repeat (100) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        total++;
        if ({out_valid, A, R, dbz, ovf} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: ov=%b A=%h R=%h want zero", out_valid, A, R);
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_ready: got %b want 1", in_ready);
        end
        // No stray result may appear after the abort
        lat = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) lat++;
        end
        total++;
        if (lat != 0) begin
            bad++;
            $display("FAIL abort_no_output: out_valid seen %0d cycles want 0", lat);
        end
        test_exact("after_abort");
    endtask

    initial begin
        t1_a = 256'h89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524;
        t1_b = 64'h1e8dcd3d3b23f176;
        t1_p = P_W'(t1_a) * P_W'(t1_b);
        test_reset();
        test_exact("exact");
        test_ops();
        test_back_to_back();
        test_reset_abort();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
